// File: rtl/cpu_dbg_ctrl.sv
// CPU debug controller: register-mapped program loader, run/halt/step control
// with a PC breakpoint, and an AXI-Stream dump of the PC and CPU registers.
module cpu_dbg_ctrl #(
   parameter int CODE_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_DUMP_REGS   = 4,
   parameter int STEP_WIDTH      = 16,
   parameter int BOOT_RUN        = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [3:0]                            reg_addr,
   input  logic [31:0]                           reg_data,
   input  logic                                  reg_strb,
   input  logic                                  fetch_strb,
   input  logic [CODE_ADDR_WIDTH-1:0]            fetch_pc,
   input  logic [NUM_DUMP_REGS*DATA_WIDTH-1:0]   dump_regs,
   output logic                                  programming,
   output logic                                  cpu_run,
   output logic [CODE_ADDR_WIDTH-1:0]            inst_mem_wr_addr,
   output logic                                  inst_mem_wr_en,
   output logic [3:0]                            jmp_off_wr_addr,
   output logic                                  jmp_off_wr_en,
   output logic [3:0]                            imm_wr_addr,
   output logic                                  imm_wr_en,
   output logic [DATA_WIDTH-1:0]                 dbg_TDATA,
   output logic                                  dbg_TVALID,
   input  logic                                  dbg_TREADY,
   output logic                                  dbg_TLAST
);

   localparam int BEAT_W = (NUM_DUMP_REGS < 1) ? 1 : $clog2(NUM_DUMP_REGS + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_DUMP_REGS);

   typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP, S_DUMP} state_t;

   state_t                              state;
   logic [STEP_WIDTH-1:0]               steps_left;
   logic [CODE_ADDR_WIDTH-1:0]          bkpt_addr;
   logic [CODE_ADDR_WIDTH-1:0]          last_pc;
   logic [CODE_ADDR_WIDTH-1:0]          pc_now;
   logic                                bkpt_en;
   logic                                auto_dump;
   logic [BEAT_W-1:0]                   beat_idx;
   logic [NUM_DUMP_REGS*DATA_WIDTH-1:0] snap_regs;
   logic [DATA_WIDTH-1:0]               next_word;
   logic wr_prog, wr_inst, wr_jmp, wr_imm, wr_mode, wr_step, wr_bkpt, wr_dump;
   logic running, bkpt_hit, step_done, dump_enter, beat_adv, beat_last;
   logic unused_reg_data;

   assign wr_prog = reg_strb && (reg_addr == 4'd0);
   assign wr_inst = reg_strb && (reg_addr == 4'd1);
   assign wr_jmp  = reg_strb && (reg_addr == 4'd2);
   assign wr_imm  = reg_strb && (reg_addr == 4'd3);
   assign wr_mode = reg_strb && (reg_addr == 4'd4);
   assign wr_step = reg_strb && (reg_addr == 4'd5);
   assign wr_bkpt = reg_strb && (reg_addr == 4'd6);
   assign wr_dump = reg_strb && (reg_addr == 4'd7);

   assign inst_mem_wr_en = wr_inst && programming;
   assign jmp_off_wr_en  = wr_jmp && programming;
   assign imm_wr_en      = wr_imm && programming;

   assign running    = (state == S_RUN) || (state == S_STEP);
   assign cpu_run    = running && !programming;
   assign bkpt_hit   = running && fetch_strb && bkpt_en && (fetch_pc == bkpt_addr);
   assign step_done  = (state == S_STEP) && fetch_strb && (steps_left == STEP_WIDTH'(1));
   assign dump_enter = !wr_prog && ((bkpt_hit && auto_dump) || ((state == S_HALT) && wr_dump));
   assign beat_adv   = (state == S_DUMP) && dbg_TVALID && dbg_TREADY && !wr_prog;
   assign beat_last  = (beat_idx == LAST_BEAT);
   // The PC reported is that of the instruction fetched in the entry cycle, if any.
   assign pc_now     = fetch_strb ? fetch_pc : last_pc;
   assign unused_reg_data = ^reg_data;

   always_comb begin
      next_word = '0;
      for (int i = 0; i < NUM_DUMP_REGS; i++) begin
         if (beat_idx == BEAT_W'(i)) next_word = snap_regs[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= (BOOT_RUN != 0) ? S_RUN : S_HALT;
         programming      <= 1'b0;
         inst_mem_wr_addr <= '0;
         jmp_off_wr_addr  <= '0;
         imm_wr_addr      <= '0;
         steps_left       <= '0;
         bkpt_addr        <= '0;
         bkpt_en          <= 1'b0;
         auto_dump        <= 1'b0;
         last_pc          <= '0;
         beat_idx         <= '0;
         dbg_TVALID       <= 1'b0;
         dbg_TLAST        <= 1'b0;
      end else begin
         if (fetch_strb) last_pc <= fetch_pc;
         if (wr_prog) begin
            programming      <= reg_data[0];
            inst_mem_wr_addr <= '0;
            jmp_off_wr_addr  <= '0;
            imm_wr_addr      <= '0;
            state            <= S_HALT;
            dbg_TVALID       <= 1'b0;
            dbg_TLAST        <= 1'b0;
         end else begin
            if (inst_mem_wr_en) inst_mem_wr_addr <= inst_mem_wr_addr + 1'b1;
            if (jmp_off_wr_en)  jmp_off_wr_addr  <= jmp_off_wr_addr + 1'b1;
            if (imm_wr_en)      imm_wr_addr      <= imm_wr_addr + 1'b1;
            if (wr_bkpt && (state != S_DUMP)) begin
               bkpt_addr <= reg_data[CODE_ADDR_WIDTH-1:0];
               bkpt_en   <= reg_data[31];
               auto_dump <= reg_data[30];
            end
            case (state)
               S_RUN, S_STEP: begin
                  if ((state == S_STEP) && fetch_strb) steps_left <= steps_left - 1'b1;
                  if (bkpt_hit)       state <= auto_dump ? S_DUMP : S_HALT;
                  else if (step_done) state <= S_HALT;
                  else if (wr_mode)   state <= reg_data[0] ? S_RUN : S_HALT;
               end
               S_HALT: begin
                  if (wr_mode) begin
                     state <= reg_data[0] ? S_RUN : S_HALT;
                  end else if (wr_step && (reg_data[STEP_WIDTH-1:0] != '0)) begin
                     steps_left <= reg_data[STEP_WIDTH-1:0];
                     state      <= S_STEP;
                  end else if (wr_dump) begin
                     state <= S_DUMP;
                  end
               end
               default: begin
                  if (beat_adv) begin
                     if (beat_last) begin
                        dbg_TVALID <= 1'b0;
                        dbg_TLAST  <= 1'b0;
                        state      <= S_HALT;
                     end else begin
                        beat_idx  <= beat_idx + 1'b1;
                        dbg_TLAST <= (beat_idx == LAST_BEAT - 1'b1);
                     end
                  end
               end
            endcase
            if (dump_enter) begin
               dbg_TVALID <= 1'b1;
               dbg_TLAST  <= (NUM_DUMP_REGS == 0);
               beat_idx   <= '0;
            end
         end
      end
   end

   // Dump datapath: snapshot on entry, then walk the snapshot one beat per handshake.
   always_ff @(posedge clk) begin
      if (dump_enter) begin
         snap_regs <= dump_regs;
         dbg_TDATA <= DATA_WIDTH'(pc_now);
      end else if (beat_adv && !beat_last) begin
         dbg_TDATA <= next_word;
      end
   end

endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
// Scoreboard bench for cpu_dbg_ctrl: dump beats are queued when a dump is
// provoked and popped by a stream monitor; control outputs are checked inline.
module tb_cpu_dbg_ctrl;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam logic [3:0] A_PROG = 4'd0, A_INST = 4'd1, A_JMP = 4'd2, A_IMM = 4'd3,
                          A_MODE = 4'd4, A_STEP = 4'd5, A_BKPT = 4'd6, A_DUMP = 4'd7;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       reg_addr;
   logic [31:0]      reg_data;
   logic             reg_strb;
   logic             fetch_strb;
   logic [AW-1:0]    fetch_pc;
   logic [NR*DW-1:0] dump_regs;
   logic             programming, cpu_run;
   logic [AW-1:0]    inst_mem_wr_addr;
   logic             inst_mem_wr_en;
   logic [3:0]       jmp_off_wr_addr, imm_wr_addr;
   logic             jmp_off_wr_en, imm_wr_en;
   logic [DW-1:0]    dbg_TDATA;
   logic             dbg_TVALID, dbg_TREADY, dbg_TLAST;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            beat_cnt = 0;
   beat_t         q[$];
   beat_t         exp_b;
   bit            hold_pend = 1'b0;
   logic [DW-1:0] hold_data;
   logic          hold_last;
   logic [AW-1:0] m_inst;
   logic [3:0]    m_jmp, m_imm;

   always #5 clk = ~clk;

   cpu_dbg_ctrl #(
      .CODE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_DUMP_REGS(NR),
      .STEP_WIDTH(16), .BOOT_RUN(1)
   ) dut (
      .clk(clk), .rst(rst),
      .reg_addr(reg_addr), .reg_data(reg_data), .reg_strb(reg_strb),
      .fetch_strb(fetch_strb), .fetch_pc(fetch_pc), .dump_regs(dump_regs),
      .programming(programming), .cpu_run(cpu_run),
      .inst_mem_wr_addr(inst_mem_wr_addr), .inst_mem_wr_en(inst_mem_wr_en),
      .jmp_off_wr_addr(jmp_off_wr_addr), .jmp_off_wr_en(jmp_off_wr_en),
      .imm_wr_addr(imm_wr_addr), .imm_wr_en(imm_wr_en),
      .dbg_TDATA(dbg_TDATA), .dbg_TVALID(dbg_TVALID),
      .dbg_TREADY(dbg_TREADY), .dbg_TLAST(dbg_TLAST)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      reg_addr = a;
      reg_data = d;
      reg_strb = 1'b1;
      tick();
      reg_strb = 1'b0;
   endtask

   task automatic wr_prog_reg(input logic v);
      wr(A_PROG, {31'd0, v});
      m_inst = '0;
      m_jmp  = '0;
      m_imm  = '0;
   endtask

   // Loader write: check the combinational strobe and current address, then commit.
   task automatic prog_wr(input logic [3:0] a, input logic [31:0] d, input logic exp_en);
      reg_addr = a;
      reg_data = d;
      reg_strb = 1'b1;
      #1;
      if (a == A_INST) begin
         chk("inst_en", inst_mem_wr_en, exp_en);
         chk("inst_addr", inst_mem_wr_addr, m_inst);
      end else if (a == A_JMP) begin
         chk("jmp_en", jmp_off_wr_en, exp_en);
         chk("jmp_addr", jmp_off_wr_addr, m_jmp);
      end else begin
         chk("imm_en", imm_wr_en, exp_en);
         chk("imm_addr", imm_wr_addr, m_imm);
      end
      tick();
      reg_strb = 1'b0;
      if (exp_en) begin
         if (a == A_INST)     m_inst = m_inst + 1'b1;
         else if (a == A_JMP) m_jmp  = m_jmp + 1'b1;
         else                 m_imm  = m_imm + 1'b1;
      end
   endtask

   task automatic fetch(input logic [AW-1:0] pc);
      fetch_pc   = pc;
      fetch_strb = 1'b1;
      tick();
      fetch_strb = 1'b0;
   endtask

   task automatic set_regs(input logic [31:0] r0, r1, r2, r3);
      dump_regs = {r3, r2, r1, r0};
   endtask

   task automatic push_dump(input logic [DW-1:0] pc);
      beat_t b;
      b.data = pc;
      b.last = 1'b0;
      q.push_back(b);
      for (int i = 0; i < NR; i++) begin
         b.data = dump_regs[i*DW +: DW];
         b.last = (i == NR - 1);
         q.push_back(b);
      end
   endtask

   task automatic drain(input int stall_beat, input int base, output int cycles);
      int stalls;
      stalls = 0;
      cycles = 0;
      while (q.size() != 0 && cycles < 40) begin
         if (stall_beat >= 0 && (beat_cnt - base) == stall_beat && stalls < 3) begin
            dbg_TREADY = 1'b0;
            stalls++;
         end else begin
            dbg_TREADY = 1'b1;
         end
         tick();
         cycles++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   // Stream monitor: handshakes pop the scoreboard; stalled beats must hold.
   always @(negedge clk) begin
      if (hold_pend && dbg_TVALID === 1'b1) begin
         chk("hold_data", dbg_TDATA, hold_data);
         chk("hold_last", dbg_TLAST, hold_last);
      end
      if (dbg_TVALID === 1'b1 && dbg_TREADY === 1'b1) begin
         beat_cnt++;
         chk("beat_expected", (q.size() != 0), 1);
         if (q.size() != 0) begin
            exp_b = q.pop_front();
            chk("beat_data", dbg_TDATA, exp_b.data);
            chk("beat_last", dbg_TLAST, exp_b.last);
         end
      end
      hold_pend = (dbg_TVALID === 1'b1) && (dbg_TREADY === 1'b0);
      hold_data = dbg_TDATA;
      hold_last = dbg_TLAST;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int base;
      rst = 1'b1; reg_addr = '0; reg_data = '0; reg_strb = 1'b0;
      fetch_strb = 1'b0; fetch_pc = '0; dump_regs = '0; dbg_TREADY = 1'b0;
      m_inst = '0; m_jmp = '0; m_imm = '0;
      tick(); tick();
      chk("rst_programming", programming, 0);
      chk("rst_cpu_run", cpu_run, 1);
      chk("rst_inst_addr", inst_mem_wr_addr, 0);
      chk("rst_jmp_addr", jmp_off_wr_addr, 0);
      chk("rst_imm_addr", imm_wr_addr, 0);
      chk("rst_tvalid", dbg_TVALID, 0);
      chk("rst_tlast", dbg_TLAST, 0);
      rst = 1'b0;
      tick();
      chk("boot_run", cpu_run, 1);

      // Program load
      wr_prog_reg(1'b1);
      chk("prog_on", programming, 1);
      chk("prog_run_off", cpu_run, 0);
      prog_wr(A_INST, 32'hAA, 1'b1);
      prog_wr(A_INST, 32'hBB, 1'b1);
      prog_wr(A_JMP, 32'h1, 1'b1);
      prog_wr(A_IMM, 32'h2, 1'b1);
      prog_wr(A_IMM, 32'h3, 1'b1);
      wr(A_MODE, 32'd1);
      chk("prog_gates_run", cpu_run, 0);
      wr_prog_reg(1'b0);
      chk("prog_off", programming, 0);
      chk("prog_off_halt", cpu_run, 0);
      chk("prog_clr_inst", inst_mem_wr_addr, 0);
      chk("prog_clr_imm", imm_wr_addr, 0);
      prog_wr(A_INST, 32'hCC, 1'b0);

      // Single stepping
      wr(A_STEP, 32'd0);
      chk("step0_ignored", cpu_run, 0);
      wr(A_STEP, 32'd3);
      chk("step_run", cpu_run, 1);
      for (int i = 0; i < 3; i++) begin
         fetch(AW'(10'h10 + i));
         chk("step_after_fetch", cpu_run, (i < 2));
         tick();
         chk("step_gap", cpu_run, (i < 2));
      end
      wr(A_MODE, 32'd1);
      chk("mode_run", cpu_run, 1);
      wr(A_MODE, 32'd0);
      chk("mode_halt", cpu_run, 0);

      // Breakpoint with auto dump
      wr(A_MODE, 32'd1);
      wr(A_BKPT, 32'hC000_0005);
      fetch(10'h3);
      chk("bkpt_miss", cpu_run, 1);
      set_regs(32'd1, 32'd2, 32'd3, 32'd4);
      dbg_TREADY = 1'b1;
      push_dump(32'd5);
      fetch(10'h5);
      chk("bkpt_stop", cpu_run, 0);
      chk("bkpt_first_valid", dbg_TVALID, 1);
      drain(-1, 0, cyc);
      chk("dump_cycles", cyc, NR + 1);
      chk("dump_done_valid", dbg_TVALID, 0);
      chk("dump_done_halt", cpu_run, 0);

      // Host-requested dump with backpressure on beat 2
      set_regs(32'h11, 32'h22, 32'h33, 32'h44);
      base = beat_cnt;
      push_dump(32'd5);
      wr(A_DUMP, 32'd0);
      drain(2, base, cyc);
      chk("stall_beats", beat_cnt - base, NR + 1);
      chk("stall_cycles", cyc, NR + 4);

      // Control writes during a dump are ignored
      dbg_TREADY = 1'b0;
      set_regs(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      base = beat_cnt;
      push_dump(32'd5);
      wr(A_DUMP, 32'd0);
      wr(A_MODE, 32'd1);
      chk("dump_mode_ign", cpu_run, 0);
      chk("dump_still_valid", dbg_TVALID, 1);
      wr(A_STEP, 32'd5);
      chk("dump_step_ign", cpu_run, 0);
      wr(A_BKPT, 32'd0);
      wr(A_DUMP, 32'd0);
      chk("dump_pc_held", dbg_TDATA, 32'd5);
      drain(-1, base, cyc);
      chk("ign_beats", beat_cnt - base, NR + 1);
      wr(A_MODE, 32'd1);
      set_regs(32'hB0, 32'hB1, 32'hB2, 32'hB3);
      push_dump(32'd5);
      fetch(10'h5);
      chk("bkpt_kept", cpu_run, 0);
      drain(-1, 0, cyc);

      // Same-cycle priorities
      wr(A_MODE, 32'd1);
      wr(A_BKPT, 32'h8000_0007);
      reg_addr = A_MODE; reg_data = 32'd1; reg_strb = 1'b1;
      fetch_pc = 10'h7; fetch_strb = 1'b1;
      tick();
      reg_strb = 1'b0; fetch_strb = 1'b0;
      chk("hit_over_mode", cpu_run, 0);
      chk("hit_no_dump", dbg_TVALID, 0);
      wr(A_STEP, 32'd1);
      chk("step1_run", cpu_run, 1);
      reg_addr = A_MODE; reg_data = 32'd1; reg_strb = 1'b1;
      fetch_pc = 10'h20; fetch_strb = 1'b1;
      tick();
      reg_strb = 1'b0; fetch_strb = 1'b0;
      chk("step_over_mode", cpu_run, 0);

      // PROG write aborts a dump
      dbg_TREADY = 1'b0;
      set_regs(32'hC0, 32'hC1, 32'hC2, 32'hC3);
      wr(A_DUMP, 32'd0);
      chk("abort_valid_pre", dbg_TVALID, 1);
      chk("abort_pc", dbg_TDATA, 32'h20);
      wr_prog_reg(1'b1);
      chk("abort_valid", dbg_TVALID, 0);
      chk("abort_tlast", dbg_TLAST, 0);
      dbg_TREADY = 1'b1;
      tick(); tick();

      // Address wrap
      for (int i = 0; i < (1 << AW); i++) prog_wr(A_INST, i, 1'b1);
      prog_wr(A_INST, 32'hFFFF, 1'b1);
      chk("inst_wrap_next", inst_mem_wr_addr, 1);
      for (int i = 0; i < 16; i++) prog_wr(A_JMP, i, 1'b1);
      prog_wr(A_JMP, 32'h55, 1'b1);
      chk("jmp_wrap_next", jmp_off_wr_addr, 1);

      // Reset during the final beat
      wr_prog_reg(1'b0);
      dbg_TREADY = 1'b1;
      set_regs(32'hD0, 32'hD1, 32'hD2, 32'hD3);
      push_dump(32'h20);
      wr(A_DUMP, 32'd0);
      repeat (4) tick();
      dbg_TREADY = 1'b0;
      chk("final_tlast", dbg_TLAST, 1);
      chk("final_data", dbg_TDATA, 32'hD3);
      chk("final_left", q.size(), 1);
      q.delete();
      rst = 1'b1;
      tick();
      chk("rstdump_valid", dbg_TVALID, 0);
      chk("rstdump_tlast", dbg_TLAST, 0);
      chk("rstdump_prog", programming, 0);
      chk("rstdump_run", cpu_run, 1);
      chk("rstdump_jmp", jmp_off_wr_addr, 0);
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_dbg_ctrl.md
CPU_DBG_CTRL -- requirements
Module: cpu_dbg_ctrl

Interface
REQ-001 SHALL have parameters: CODE_ADDR_WIDTH, default 10, instruction address width; DATA_WIDTH, default 32, debug word and CPU register width; NUM_DUMP_REGS, default 4, registers dumped after header; STEP_WIDTH, default 16, step counter width; BOOT_RUN, default 1, reset state RUN if 1, else HALT.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset.
REQ-003 SHALL have ports: reg_addr  in  4  register map address; reg_data  in  32  register map data; reg_strb  in  1  register map write strobe.
REQ-004 SHALL have ports: fetch_strb  in  1  CPU consumed one instruction; fetch_pc  in  CODE_ADDR_WIDTH  address of that instruction; dump_regs  in  NUM_DUMP_REGS*DATA_WIDTH  flattened CPU registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-005 SHALL have ports: programming  out  1  CPU held in reset; cpu_run  out  1  fetch enable (gates inst_rd_en).
REQ-006 SHALL have ports: inst_mem_wr_addr  out  CODE_ADDR_WIDTH; inst_mem_wr_en  out  1; jmp_off_wr_addr  out  4; jmp_off_wr_en  out  1; imm_wr_addr  out  4; imm_wr_en  out  1; write data is reg_data, sliced by the consumer.
REQ-007 SHALL have ports: dbg_TDATA  out  DATA_WIDTH; dbg_TVALID  out  1; dbg_TREADY  in  1; dbg_TLAST  out  1.
REQ-008 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-009 SHALL decode reg_addr: 0 PROG, 1 INST, 2 JMP_OFF, 3 IMM, 4 MODE, 5 STEP, 6 BKPT, 7 DUMP; other addresses ignored.
REQ-010 PROG write SHALL set programming to reg_data[0], zero all three write addresses, abort any dump, and enter HALT.
REQ-011 INST/JMP_OFF/IMM writes SHALL assert the matching wr_en combinationally with reg_strb and post-increment the address, only while programming=1; ignored otherwise.
REQ-012 Write addresses SHALL wrap modulo 2^width (inst 2^CODE_ADDR_WIDTH-1 -> 0, jmp/imm 15 -> 0).
REQ-013 SHALL implement states RUN, HALT, STEP, DUMP; cpu_run=1 only in RUN and STEP, and 0 whenever programming=1.
REQ-014 MODE write (HALT/RUN/STEP only): reg_data[0]=1 -> RUN, 0 -> HALT.
REQ-015 STEP write in HALT with reg_data[STEP_WIDTH-1:0]=N>0 SHALL load steps_left=N and enter STEP; N=0 or write in other states ignored.
REQ-016 In STEP each fetch_strb SHALL decrement steps_left; fetch_strb with steps_left=1 -> HALT next cycle (cpu_run low in cycle t+1).
REQ-017 BKPT write SHALL store bkpt_addr=reg_data[CODE_ADDR_WIDTH-1:0], bkpt_en=reg_data[31], auto_dump=reg_data[30].
REQ-018 fetch_strb in RUN/STEP with bkpt_en and fetch_pc==bkpt_addr SHALL leave RUN/STEP next cycle (the bkpt instruction issues): to DUMP if auto_dump, else HALT.
REQ-019 Priority in one cycle: PROG write > breakpoint hit > step exhaustion > MODE/STEP write.
REQ-020 DUMP write in HALT SHALL enter DUMP; ignored in other states.
REQ-021 On DUMP entry SHALL snapshot fetch-time PC (last fetch_pc seen with fetch_strb, 0 after reset) and all dump_regs.
REQ-022 DUMP SHALL emit NUM_DUMP_REGS+1 beats: beat 0 = PC zero-extended, beat k = snapshot reg k-1; TLAST only on last beat; then HALT.
REQ-023 dbg_TDATA/TLAST SHALL hold stable while TVALID=1 and TREADY=0; a beat advances only on TVALID&TREADY.
REQ-024 First dump beat SHALL be valid the cycle after DUMP entry; back-to-back beats with TREADY=1 at one per cycle.
REQ-025 MODE/STEP/BKPT/DUMP writes during DUMP SHALL be ignored.

Reset
REQ-026 On rst: programming=0, all wr_addr=0, all wr_en=0, steps_left=0, bkpt_en=0, auto_dump=0, last PC=0, dbg_TVALID=0, dbg_TLAST=0, state RUN if BOOT_RUN else HALT.
REQ-027 rst mid-dump SHALL drop dbg_TVALID the next cycle without TLAST.

Verification
REQ-028 PROG=1, INST writes 0xAA,0xBB, PROG=0 -> inst_mem_wr_en pulses at addr 0,1; state HALT, cpu_run=0; INST write afterward -> no wr_en.
REQ-029 HALT, STEP=3, fetch_strb on 3 separate cycles -> cpu_run high until cycle after third strobe, then HALT.
REQ-030 RUN, BKPT=0xC0000005 (en, auto_dump), fetch_strb pc=5, regs {1,2,3,4} -> dbg beats 5,1,2,3,4, TLAST on 4, then HALT.
REQ-031 Dump with TREADY low 3 cycles on beat 2 -> beat 2 data held stable; total beats still 5.
REQ-032 Same cycle: breakpoint hit and MODE write RUN -> HALT; PROG=1 during dump -> TVALID low next cycle, no TLAST.
REQ-033 Programming 2^CODE_ADDR_WIDTH+1 instructions -> final write at addr 0 (wrap).
